// File: rtl/hr_pkg.sv
// Shared types and helpers for the heart-rate measurement sequencer.
package hr_pkg;
  typedef enum logic [1:0] {
    CV_IDLE = 2'd0,
    CV_HUND = 2'd1,
    CV_TENS = 2'd2,
    CV_DONE = 2'd3
  } cv_state_t;

  localparam int BPM_MAX = 255;

  typedef logic [3:0] bcd_t;

  function automatic logic [7:0] sat_bpm(input logic [11:0] prod);
    if (prod > 12'd255) begin
      sat_bpm = 8'd255;
    end else begin
      sat_bpm = prod[7:0];
    end
  endfunction
endpackage

// File: rtl/heart_rate_ctrl_bin2bcd_seq.sv
// Sequential subtractive binary-to-BCD converter for an 8-bit value.
module bin2bcd_seq import hr_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  output logic       done,
  output logic       busy,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  cv_state_t  state, state_n;
  logic [7:0] work, work_n;
  bcd_t       h, h_n, t, t_n;

  // Next-state logic: one subtraction per cycle, hundreds before tens.
  always_comb begin
    state_n = state;
    work_n  = work;
    h_n     = h;
    t_n     = t;
    case (state)
      CV_IDLE: begin
        if (start) begin
          state_n = CV_HUND;
          work_n  = value;
          h_n     = 4'd0;
          t_n     = 4'd0;
        end else begin
          state_n = CV_IDLE;
        end
      end
      CV_HUND: begin
        if (work >= 8'd100) begin
          work_n = work - 8'd100;
          h_n    = h + 4'd1;
        end else begin
          state_n = CV_TENS;
        end
      end
      CV_TENS: begin
        if (work >= 8'd10) begin
          work_n = work - 8'd10;
          t_n    = t + 4'd1;
        end else begin
          state_n = CV_DONE;
        end
      end
      CV_DONE: state_n = CV_IDLE;
      default: state_n = CV_IDLE;
    endcase
  end

  // State and working registers; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CV_IDLE;
      work  <= 8'd0;
      h     <= 4'd0;
      t     <= 4'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      work  <= work_n;
      h     <= h_n;
      t     <= t_n;
      busy  <= (state_n != CV_IDLE);
    end
  end

  assign done = (state == CV_DONE);
  assign hund = h;
  assign tens = t;
  assign ones = work[3:0];
endmodule

// File: rtl/heart_rate_ctrl_chk.sv
// Protocol checker: a window must never end while a conversion is still running.
module heart_rate_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic terminal,
  input logic busy
);
  a_no_overlap: assert property (@(posedge clk) disable iff (!reset) terminal |-> !busy);
endmodule

// File: rtl/heart_rate_ctrl.sv
// Peak counting over fixed windows with refractory lockout, BPM scaling and atomic BCD publish.
module heart_rate_ctrl import hr_pkg::*; #(
  parameter int WINDOW_CYCLES  = 400_000_000,
  parameter int REFRACT_CYCLES = 12_000_000,
  parameter int BPM_SCALE      = 6,
  parameter int CNT_W          = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       peak_in,
  output logic [7:0] bpm,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       update,
  output logic       no_signal,
  output logic       busy
);
  localparam logic [CNT_W-1:0] WIN_MAX      = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFRACT_LOAD = CNT_W'(REFRACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [11:0]      SCALE12      = 12'(BPM_SCALE);

  logic             peak_d, rise, accept, terminal;
  logic [CNT_W-1:0] win_cnt, refract_cnt;
  logic [7:0]       peak_cnt, peak_cnt_next, snap, scaled;
  logic [11:0]      product;
  logic             cv_done;
  logic [3:0]       cv_h, cv_t, cv_o;

  // Accept decision and the scaled count that a terminal cycle would capture.
  always_comb begin
    rise     = peak_in & ~peak_d;
    accept   = rise & enable & (refract_cnt == CNT_ZERO);
    terminal = enable & (win_cnt == WIN_MAX);
    if (accept && (peak_cnt != 8'd255)) begin
      peak_cnt_next = peak_cnt + 8'd1;
    end else begin
      peak_cnt_next = peak_cnt;
    end
    product = {4'd0, peak_cnt_next} * SCALE12;
    scaled  = sat_bpm(product);
  end

  // Edge detect, window/peak/refractory counters and window snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_d      <= 1'b0;
      win_cnt     <= CNT_ZERO;
      refract_cnt <= CNT_ZERO;
      peak_cnt    <= 8'd0;
      snap        <= 8'd0;
    end else begin
      peak_d <= peak_in;
      if (terminal) begin
        snap <= scaled;
      end
      if (!enable) begin
        win_cnt     <= CNT_ZERO;
        peak_cnt    <= 8'd0;
        refract_cnt <= CNT_ZERO;
      end else begin
        win_cnt  <= terminal ? CNT_ZERO : win_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        peak_cnt <= terminal ? 8'd0 : peak_cnt_next;
        if (accept) begin
          refract_cnt <= REFRACT_LOAD;
        end else if (refract_cnt != CNT_ZERO) begin
          refract_cnt <= refract_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (terminal),
    .value (scaled),
    .done  (cv_done),
    .busy  (busy),
    .hund  (cv_h),
    .tens  (cv_t),
    .ones  (cv_o)
  );

  // Published outputs change together, only on the conversion's final cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bpm       <= 8'd0;
      digit2    <= 4'd0;
      digit1    <= 4'd0;
      digit0    <= 4'd0;
      update    <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      update <= cv_done;
      if (cv_done) begin
        bpm       <= snap;
        digit2    <= cv_h;
        digit1    <= cv_t;
        digit0    <= cv_o;
        no_signal <= (snap == 8'd0);
      end
    end
  end

  heart_rate_ctrl_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .terminal (terminal),
    .busy     (busy)
  );
endmodule

// File: tb/tb_heart_rate_ctrl.sv
// Directed bench: dut a uses a 1000-cycle window, dut b a 4000-cycle window for saturation.
module tb_heart_rate_ctrl;
  logic clk = 1'b0;
  logic reset, enable, peak_in;
  logic [7:0] bpm, b_bpm;
  logic [3:0] digit2, digit1, digit0, b_digit2, b_digit1, b_digit0;
  logic update, no_signal, busy, b_update, b_no_signal, b_busy;
  int checks = 0;
  int failures = 0;
  int edges = 0;

  always #5 clk = ~clk;

  heart_rate_ctrl #(.WINDOW_CYCLES(1000), .REFRACT_CYCLES(50), .BPM_SCALE(6), .CNT_W(29)) dut (
    .clk(clk), .reset(reset), .enable(enable), .peak_in(peak_in),
    .bpm(bpm), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .update(update), .no_signal(no_signal), .busy(busy));

  heart_rate_ctrl #(.WINDOW_CYCLES(4000), .REFRACT_CYCLES(50), .BPM_SCALE(6), .CNT_W(29)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .peak_in(peak_in),
    .bpm(b_bpm), .digit2(b_digit2), .digit1(b_digit1), .digit0(b_digit0),
    .update(b_update), .no_signal(b_no_signal), .busy(b_busy));

  task automatic tick;
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic run_until(input int n);
    while (edges < n) tick();
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; peak_in = 1'b0;
    tick(); tick();
    reset = 1'b1; edges = 0;
    run_until(100); peak_in = 1'b1; run_until(105); peak_in = 1'b0;
    run_until(300);
    reset = 1'b0; tick(); tick();
    checks++; if (bpm !== 8'd0) begin failures++; $display("FAIL reset_bpm got=%0d exp=0", bpm); end
    checks++; if ({digit2, digit1, digit0} !== 12'h000) begin failures++; $display("FAIL reset_digits got=%h exp=000", {digit2, digit1, digit0}); end
    checks++; if ({update, no_signal, busy} !== 3'b010) begin failures++; $display("FAIL reset_flags got=%b exp=010", {update, no_signal, busy}); end
    checks++; if ({b_bpm, b_update, b_no_signal, b_busy} !== {8'd0, 3'b010}) begin failures++; $display("FAIL reset_b got=%h exp=002", {b_bpm, b_update, b_no_signal, b_busy}); end
    reset = 1'b1; edges = 0;
  endtask

  // Drives one window's pulse train on dut a and checks the resulting publish.
  task automatic run_window(input string nm, input int base, input int first, input int spacing,
                            input int count, input int width, input logic [7:0] exp_bpm,
                            input logic [11:0] exp_dig, input logic exp_ns);
    int term, lat;
    for (int i = 0; i < count; i++) begin
      run_until(base + first + i * spacing); peak_in = 1'b1;
      run_until(base + first + i * spacing + width); peak_in = 1'b0;
    end
    term = base + 999;
    lat = int'(exp_dig[11:8]) + int'(exp_dig[7:4]) + 3;
    run_until(term + 1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b exp=1", nm, busy); end
    run_until(term + lat);
    checks++; if (update !== 1'b0) begin failures++; $display("FAIL %s_early_update got=%b exp=0", nm, update); end
    tick();
    checks++; if (update !== 1'b1) begin failures++; $display("FAIL %s_update got=%b exp=1", nm, update); end
    checks++; if (bpm !== exp_bpm) begin failures++; $display("FAIL %s_bpm got=%0d exp=%0d", nm, bpm, exp_bpm); end
    checks++; if ({digit2, digit1, digit0} !== exp_dig) begin failures++; $display("FAIL %s_digits got=%h exp=%h", nm, {digit2, digit1, digit0}, exp_dig); end
    checks++; if (no_signal !== exp_ns) begin failures++; $display("FAIL %s_no_signal got=%b exp=%b", nm, no_signal, exp_ns); end
    tick();
    checks++; if ({update, busy} !== 2'b00) begin failures++; $display("FAIL %s_after got=%b exp=00", nm, {update, busy}); end
  endtask

  task automatic test_basic;
    run_window("basic", 0, 10, 80, 12, 5, 8'd72, 12'h072, 1'b0);
  endtask

  task automatic test_refractory;
    run_window("refract20", 1000, 30, 20, 2, 5, 8'd6, 12'h006, 1'b0);
    run_window("refract50", 2000, 30, 50, 2, 5, 8'd12, 12'h012, 1'b0);
  endtask

  task automatic test_boundary;
    run_window("term_rise", 3000, 999, 1, 1, 1, 8'd6, 12'h006, 1'b0);
    run_window("empty", 4000, 0, 1, 0, 1, 8'd0, 12'h000, 1'b1);
  endtask

  task automatic test_enable;
    logic seen;
    seen = 1'b0;
    run_until(5100); peak_in = 1'b1; run_until(5105); peak_in = 1'b0;
    while (edges < 6603) begin
      if (edges == 5500) enable = 1'b0;
      if (edges == 5600) enable = 1'b1;
      if (edges == 5700 || edges == 5800) peak_in = 1'b1;
      if (edges == 5705 || edges == 5805) peak_in = 1'b0;
      tick();
      if (update !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL enable_no_update got=%b exp=0", seen); end
    tick();
    checks++; if (update !== 1'b1) begin failures++; $display("FAIL enable_update got=%b exp=1", update); end
    checks++; if ({bpm, digit2, digit1, digit0} !== {8'd12, 12'h012}) begin failures++; $display("FAIL enable_value got=%h exp=0c012", {bpm, digit2, digit1, digit0}); end
    tick();
  endtask

  task automatic test_reset_tens;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_until(6630 + i * 60); peak_in = 1'b1;
      run_until(6635 + i * 60); peak_in = 1'b0;
    end
    run_until(7601);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tens_busy got=%b exp=1", busy); end
    reset = 1'b0; tick(); tick();
    checks++; if ({bpm, digit2, digit1, digit0} !== 20'h00000) begin failures++; $display("FAIL tens_reset_value got=%h exp=00000", {bpm, digit2, digit1, digit0}); end
    checks++; if ({update, no_signal, busy} !== 3'b010) begin failures++; $display("FAIL tens_reset_flags got=%b exp=010", {update, no_signal, busy}); end
    reset = 1'b1; edges = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (update !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL tens_aborted got=%b exp=0", seen); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 50; i++) begin
      run_until(10 + i * 60); peak_in = 1'b1;
      run_until(15 + i * 60); peak_in = 1'b0;
    end
    run_until(4000);
    checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL sat_busy got=%b exp=1", b_busy); end
    run_until(4009);
    checks++; if (b_update !== 1'b0) begin failures++; $display("FAIL sat_early_update got=%b exp=0", b_update); end
    tick();
    checks++; if (b_update !== 1'b1) begin failures++; $display("FAIL sat_update got=%b exp=1", b_update); end
    checks++; if (b_bpm !== 8'd255) begin failures++; $display("FAIL sat_bpm got=%0d exp=255", b_bpm); end
    checks++; if ({b_digit2, b_digit1, b_digit0} !== 12'h255) begin failures++; $display("FAIL sat_digits got=%h exp=255", {b_digit2, b_digit1, b_digit0}); end
    checks++; if (b_no_signal !== 1'b0) begin failures++; $display("FAIL sat_no_signal got=%b exp=0", b_no_signal); end
    tick();
    checks++; if (b_update !== 1'b0) begin failures++; $display("FAIL sat_after got=%b exp=0", b_update); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_refractory();
    test_boundary();
    test_enable();
    test_reset_tens();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
